regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline register file: NUM_REGS x DATA_WIDTH storage, two combinational read ports, one write-back port.
- Adds write-through bypass, so a read in the same cycle as a write to the same register returns the new data.
- Adds a per-register pending-write scoreboard. Decode uses it to detect RAW hazards before operand fetch.
- Sits between the decode and write-back stages of the multistage pipeline.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- PEND_WIDTH, 2, width of each per-register pending-write counter; max in-flight writes per register = 2**PEND_WIDTH-1
- BYPASS, 1, 1 = write-through forwarding enabled; 0 = reads return stored value only

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rs  input  ADDR_WIDTH  read port 1 address
- rt  input  ADDR_WIDTH  read port 2 address
- rs_data  output  DATA_WIDTH  read port 1 data
- rt_data  output  DATA_WIDTH  read port 2 data
- rs_busy  output  1  rs has pending write(s)
- rt_busy  output  1  rt has pending write(s)
- issue_en  input  1  instruction issuing a future write to issue_addr
- issue_addr  input  ADDR_WIDTH  destination of issued instruction
- issue_ready  output  1  issue accepted this cycle
- RegWrite  input  1  write-back enable
- rd  input  ADDR_WIDTH  write-back destination
- data  input  DATA_WIDTH  write-back data
- sb_error  output  1  sticky: write-back with zero pending count

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all pending counters = 0, sb_error = 0. While in reset, RegWrite and issue_en are ignored.
- Outputs held during reset: rs_data = rt_data = 0, busy = 0, issue_ready = 1 (combinational from cleared state).
- Register 0:
  - reads always return 0 and busy = 0;
  - writes to rd=0 are discarded;
  - issue to address 0 is accepted (issue_ready=1) with no counter change;
  - write-back to rd=0 never sets sb_error.
- Reads are combinational (0-cycle latency) from the stored array.
- Bypass: if BYPASS=1, RegWrite=1, rd!=0 and rd==rs, then rs_data = data in the same cycle. Same rule for rt.
- Write: on a rising clock with RegWrite=1 and rd!=0, registers[rd] <= data.
- Busy is combinational: rs_busy = (pend[rs] != 0) & (rs != 0).
  - Bypass does not clear busy. Exception: if BYPASS=1, RegWrite, rd==rs and pend[rs]==1, then rs_busy = 0 in that cycle, because the final pending write is landing.
  - Same rule for rt.
- Pending counter update per register r (rd!=0, issue_addr!=0), on the rising edge:
  - inc = issue_en & issue_ready & (issue_addr==r);
  - dec = RegWrite & (rd==r) & (pend[r]!=0);
  - inc & dec: unchanged; inc only: +1; dec only: -1.
- issue_ready = ~(pend[issue_addr] == max) | (RegWrite & rd==issue_addr & issue_addr!=0). A simultaneous write-back frees the slot.
- When issue_ready=0, the issue is dropped. Decode must stall and hold issue_en.
- Underflow: RegWrite with rd!=0 and pend[rd]==0 still writes the data, the counter stays 0, and sb_error <= 1 (sticky until reset).
- Counters never wrap in either direction.

Test Plan:
- Reset release: reset=0 then 1, read rs=5, rt=31 -> rs_data=0, rt_data=0, rs_busy=0, rt_busy=0, issue_ready=1, sb_error=0.
- Issue/writeback:
  - issue_addr=3 at cycle 0 -> rs=3 gives rs_busy=1 from cycle 1.
  - RegWrite rd=3 data=0xDEADBEEF at cycle 4 -> same cycle rs_data=0xDEADBEEF, rs_busy=0.
  - Cycle 5: stored value 0xDEADBEEF, busy 0.
- Saturation (PEND_WIDTH=2): three issues to r7 -> pend=3.
  - Fourth issue, no write-back -> issue_ready=0, pend stays 3.
  - Repeat with RegWrite rd=7 in the same cycle -> issue_ready=1, pend stays 3.
- Register 0: RegWrite rd=0 data=0xFFFFFFFF, plus issue to 0 -> rs=0 reads 0, rs_busy=0, sb_error=0.
- Underflow: RegWrite rd=9 data=0x12345678 with pend[9]=0 -> r9=0x12345678, sb_error=1 next cycle; remains 1 until reset.
- Mid-operation reset: pend[4]=2, r4=0xAA; assert reset asynchronously between edges -> outputs immediately show r4=0, busy=0, sb_error=0. A RegWrite on the next edge while reset=0 has no effect.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Pipeline register file with write-through bypass and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned PEND_WIDTH = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  rs_busy,
  output logic                  rt_busy,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  issue_ready,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  sb_error
);

  localparam int unsigned           NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
  logic                  sb_error_q;
  logic                  sb_error_d;

  // Inputs are gated by reset so that bypass and issue are inert while held in reset.
  logic we;
  logic iss;
  logic wr_nz;
  assign we    = RegWrite & reset;
  assign iss   = issue_en & reset;
  assign wr_nz = we & (rd != '0);

  always_comb begin
    rs_data = regs_q[rs];
    rt_data = regs_q[rt];
    if (BYPASS && wr_nz && (rd == rs)) rs_data = data;
    if (BYPASS && wr_nz && (rd == rt)) rt_data = data;
    if (rs == '0) rs_data = '0;
    if (rt == '0) rt_data = '0;
  end

  // The final pending write landing this cycle releases busy early when forwarded.
  always_comb begin
    rs_busy = (pend_q[rs] != '0) && (rs != '0);
    rt_busy = (pend_q[rt] != '0) && (rt != '0);
    if (BYPASS && wr_nz && (rd == rs) && (pend_q[rs] == PEND_WIDTH'(1))) rs_busy = 1'b0;
    if (BYPASS && wr_nz && (rd == rt) && (pend_q[rt] == PEND_WIDTH'(1))) rt_busy = 1'b0;
  end

  assign issue_ready = (pend_q[issue_addr] != PEND_MAX) ||
                       (we && (rd == issue_addr) && (issue_addr != '0));
  assign sb_error    = sb_error_q;

  always_comb begin
    logic inc;
    logic dec;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      pend_d[r] = pend_q[r];
    end
    sb_error_d = sb_error_q;
    if (wr_nz) begin
      regs_d[rd] = data;
      if (pend_q[rd] == '0) sb_error_d = 1'b1;
    end
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      inc = iss && issue_ready && (issue_addr == ADDR_WIDTH'(r));
      dec = we && (rd == ADDR_WIDTH'(r)) && (pend_q[r] != '0);
      if (inc && !dec && (pend_q[r] != PEND_MAX)) pend_d[r] = pend_q[r] + 1'b1;
      else if (dec && !inc)                       pend_d[r] = pend_q[r] - 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
        pend_q[r] <= pend_d[r];
      end
      sb_error_q <= sb_error_d;
    end
  end

endmodule
